bomb_sequencer: RTL

- Game controller for the bomb-clock puzzle.
- Sequences the two-stage password hunt: 4-bit password A first, then 3-bit password B.
- Runs the countdown timer and the remaining-attempts budget, and decides between defused and exploded.
- Drives the enable, stage-select and ENTER strobe of the higher/lower hint block, and feeds the timer/attempt displays.

---
 rtl/bomb_pkg.sv | 18 +
 rtl/bomb_sequencer_sync.sv | 22 ++
 rtl/bomb_sequencer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/bomb_pkg.sv
// Shared types and constants for the bomb-clock puzzle: game states and the
// 7-segment glyphs the hint block shows.
package bomb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FASE_A,
        FASE_B,
        DESARMADA,
        EXPLODIU
    } estado_t;

    // Active-low segments, bit order gfedcba.
    localparam logic [6:0] MAIOR   = 7'b0001001;
    localparam logic [6:0] MENOR   = 7'b1000111;
    localparam logic [6:0] APAGADO = 7'b1111111;

endpackage

// File: rtl/bomb_sequencer_sync.sv
// Two-flop synchronizer followed by a registered rising-edge detector; one
// PULSO per low-to-high transition of SINAL, three clocks after it is sampled.
module sync_edge_detect (
    input  logic CLOCK,
    input  logic RESET,
    input  logic SINAL,
    output logic PULSO
);

    logic [2:0] sync_q;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            sync_q <= '0;
            PULSO  <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], SINAL};
            PULSO  <= sync_q[1] & ~sync_q[2];
        end
    end

endmodule

// File: rtl/bomb_sequencer.sv
// Game controller for the bomb-clock puzzle: two-stage password hunt, countdown
// timer, attempt budget and the defused/exploded verdict.
//
// state     | meaning
// IDLE      | waiting for START, timer frozen, hint block disabled
// FASE_A    | hunting the 4-bit password A, timer running
// FASE_B    | hunting the 3-bit password B, timer running
// DESARMADA | defused, terminal until RESET
// EXPLODIU  | exploded, terminal until RESET
module bomb_sequencer
    import bomb_pkg::*;
#(
    parameter int TICKS_PER_SEC  = 50_000_000,
    parameter int TEMPO_INICIAL  = 60,
    parameter int TEMPO_W        = 7,
    parameter int MAX_TENTATIVAS = 8,
    parameter int PENALIDADE     = 5
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic               START,
    input  logic               ENTER,
    input  logic [3:0]         TENTATIVA,
    input  logic [3:0]         SENHA_A,
    input  logic [2:0]         SENHA_B,
    output logic               ENABLE_DICA,
    output logic               ACERTOU_SENHA_A,
    output logic               ENTER_DICA,
    output logic [TEMPO_W-1:0] TEMPO_RESTANTE,
    output logic [3:0]         TENTATIVAS_RESTANTES,
    output logic               DESARMADA,
    output logic               EXPLODIU
);

    localparam int                 PRESC_W      = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX    = PRESC_W'(TICKS_PER_SEC - 1);
    localparam logic [TEMPO_W-1:0] TEMPO_RELOAD = TEMPO_W'(TEMPO_INICIAL);
    localparam logic [3:0]         TENT_RELOAD  = 4'(MAX_TENTATIVAS);
    localparam logic [TEMPO_W:0]   PEN_EXT      = (TEMPO_W + 1)'(PENALIDADE);

    estado_t            estado;
    logic [PRESC_W-1:0] prescaler;
    logic               ep;
    logic               em_jogo;
    logic               tick;
    logic               acerto;
    logic               sem_recursos;
    logic [TEMPO_W-1:0] tempo_tick;
    logic [TEMPO_W-1:0] tempo_pen;

    // Subtraction one bit wider than the counter; a set top bit means underflow.
    function automatic logic [TEMPO_W-1:0] sub_sat(input logic [TEMPO_W-1:0] a,
                                                   input logic [TEMPO_W:0]   b);
        logic [TEMPO_W:0] d;
        d = {1'b0, a} - b;
        return d[TEMPO_W] ? '0 : d[TEMPO_W-1:0];
    endfunction

    sync_edge_detect u_enter_sync (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .SINAL (ENTER),
        .PULSO (ep)
    );

    always_comb begin
        em_jogo      = (estado == bomb_pkg::FASE_A) || (estado == bomb_pkg::FASE_B);
        tick         = em_jogo && (prescaler == PRESC_MAX);
        acerto       = (estado == bomb_pkg::FASE_A) ? (TENTATIVA == SENHA_A)
                                                    : (TENTATIVA[2:0] == SENHA_B);
        sem_recursos = (TEMPO_RESTANTE == '0) || (TENTATIVAS_RESTANTES == 4'd0);
        tempo_tick   = sub_sat(TEMPO_RESTANTE, {{TEMPO_W{1'b0}}, tick});
        tempo_pen    = sub_sat(TEMPO_RESTANTE, PEN_EXT + {{TEMPO_W{1'b0}}, tick});
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            estado               <= bomb_pkg::IDLE;
            prescaler            <= '0;
            TEMPO_RESTANTE       <= TEMPO_RELOAD;
            TENTATIVAS_RESTANTES <= TENT_RELOAD;
            ENABLE_DICA          <= 1'b0;
            ACERTOU_SENHA_A      <= 1'b0;
            ENTER_DICA           <= 1'b0;
            DESARMADA            <= 1'b0;
            EXPLODIU             <= 1'b0;
        end else begin
            ENTER_DICA <= ep && em_jogo;

            if (em_jogo) begin
                prescaler <= tick ? '0 : prescaler + 1'b1;
            end

            unique case (estado)
                bomb_pkg::IDLE: begin
                    if (START) begin
                        estado               <= bomb_pkg::FASE_A;
                        prescaler            <= '0;
                        TEMPO_RESTANTE       <= TEMPO_RELOAD;
                        TENTATIVAS_RESTANTES <= TENT_RELOAD;
                        ENABLE_DICA          <= 1'b1;
                        ACERTOU_SENHA_A      <= 1'b0;
                    end
                end

                bomb_pkg::FASE_A, bomb_pkg::FASE_B: begin
                    // A correct guess outranks an exhausted timer or budget.
                    if (ep && acerto) begin
                        TEMPO_RESTANTE <= tempo_tick;
                        if (estado == bomb_pkg::FASE_A) begin
                            estado          <= bomb_pkg::FASE_B;
                            ACERTOU_SENHA_A <= 1'b1;
                        end else begin
                            estado      <= bomb_pkg::DESARMADA;
                            ENABLE_DICA <= 1'b0;
                            DESARMADA   <= 1'b1;
                        end
                    end else if (sem_recursos) begin
                        estado      <= bomb_pkg::EXPLODIU;
                        ENABLE_DICA <= 1'b0;
                        EXPLODIU    <= 1'b1;
                    end else if (ep) begin
                        TEMPO_RESTANTE       <= tempo_pen;
                        TENTATIVAS_RESTANTES <= TENTATIVAS_RESTANTES - 4'd1;
                    end else begin
                        TEMPO_RESTANTE <= tempo_tick;
                    end
                end

                default: begin
                end
            endcase
        end
    end

endmodule
